// File: rtl/proc_trace_buffer_pkg.sv
// Shared types and widths for the processor trace buffer: one trace record per
// executed instruction, packed as {PC, IR, ALU}.
package proc_trace_pkg;

    localparam int PC_W    = 7;
    localparam int IR_W    = 16;
    localparam int ALU_W   = 16;
    localparam int STATE_W = 4;
    localparam int TRACE_W = PC_W + IR_W + ALU_W;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [IR_W-1:0]  ir;
        logic [ALU_W-1:0] alu;
    } trace_rec_t;

    function automatic trace_rec_t make_rec(input logic [PC_W-1:0]  pc,
                                            input logic [IR_W-1:0]  ir,
                                            input logic [ALU_W-1:0] alu);
        trace_rec_t rec;
        rec.pc  = pc;
        rec.ir  = ir;
        rec.alu = alu;
        return rec;
    endfunction

endpackage

// File: rtl/proc_trace_buffer_mem.sv
// Trace record storage: register array with one synchronous write port and one
// asynchronous read port; contents are not reset.
module trace_mem
    import proc_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  trace_rec_t         wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output trace_rec_t         rdata_o
);

    trace_rec_t mem_q [DEPTH];

    // Storage write; only entries between rd_ptr and wr_ptr are ever observed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/proc_trace_buffer.sv
// Trace buffer top: detects entry into the capture state, logs {PC, IR, ALU} into a
// circular buffer and presents the oldest record on a first-word-fall-through read port.
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int unsigned        DEPTH        = 16,
    parameter logic [STATE_W-1:0] CAP_STATE    = 4'd1,
    parameter bit                 STOP_ON_FULL = 1'b1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Enable,
    input  logic                         Clear,
    input  logic [PC_W-1:0]              PC_In,
    input  logic [IR_W-1:0]              IR_In,
    input  logic [STATE_W-1:0]           State_In,
    input  logic [ALU_W-1:0]             ALU_In,
    input  logic                         Rd_Ready,
    output logic                         Rd_Valid,
    output logic [TRACE_W-1:0]           Rd_Data,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Empty,
    output logic                         Full,
    output logic                         Overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [STATE_W-1:0] prev_state_q;

    logic       cap_s;
    logic       pop_s;
    logic       full_s;
    logic       empty_s;
    logic       we_s;
    trace_rec_t wdata_s;
    trace_rec_t rdata_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == {CW{1'b0}});
    assign cap_s   = Enable && (State_In == CAP_STATE) && (prev_state_q != CAP_STATE);
    assign pop_s   = !empty_s && Rd_Ready;
    assign wdata_s = make_rec(PC_In, IR_In, ALU_In);

    // Next-state logic: Clear beats everything; a full buffer either drops or overwrites.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        we_s     = 1'b0;
        if (Clear) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
            ovf_d    = 1'b0;
        end else begin
            if (cap_s && (!full_s || pop_s)) begin
                we_s     = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (cap_s) begin
                // Full with no pop: in overwrite mode the oldest record is retired.
                ovf_d = 1'b1;
                if (STOP_ON_FULL) begin
                    we_s = 1'b0;
                end else begin
                    we_s     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
            end else begin
                we_s = 1'b0;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_d;
            end

            if (cap_s && !full_s && !pop_s) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_s && !cap_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers; prev_state tracks the processor FSM regardless of Enable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            ovf_q        <= 1'b0;
            prev_state_q <= {STATE_W{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            prev_state_q <= State_In;
        end
    end

    trace_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (Clk),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    assign Rd_Valid = !empty_s;
    assign Rd_Data  = rdata_s;
    assign Count    = count_q;
    assign Empty    = empty_s;
    assign Full     = full_s;
    assign Overflow = ovf_q;

endmodule
